// File: rtl/uart_pkg.sv
// Shared defaults and state encoding for the UART frame parser.
package uart_pkg;

  localparam logic [7:0] HEADER_DEF  = 8'hAA;
  localparam int         MAX_LEN_DEF = 8;
  localparam int         TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's done strobe into a one-cycle byte-accept pulse,
// so a strobe held high for several cycles yields a single byte.
module uart_byte_strobe (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       done_i,
  input  logic [7:0] data_i,
  output logic       acc_o,
  output logic [7:0] byte_o
);

  logic done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_i;
    end
  end

  assign acc_o  = done_i & ~done_q;
  assign byte_o = data_i;

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: HEADER, LEN, payload, checksum, with inter-byte timeout.
// Accepted payload and length are held until the next good frame.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEF,
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic        BPS_CLK,
  input  logic        RSTn,
  input  logic        RX_Done_Sig,
  input  logic [7:0]  RX_Data,
  output logic        FRAME_Done_Sig,
  output logic        FRAME_Err_Sig,
  output logic [3:0]  FRAME_Len,
  output logic [63:0] FRAME_Data,
  output logic        Busy_Sig
);

  localparam logic [7:0] MAXL   = 8'(MAX_LEN);
  localparam logic [7:0] TMO_M1 = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  len_q;
  logic [7:0]  sum_q;
  logic [7:0]  cnt_q;
  logic [63:0] buf_q;
  logic        done_q;
  logic        err_q;
  logic [3:0]  flen_q;
  logic [63:0] fdata_q;
  logic [63:0] fdata_d;

  logic       acc;
  logic [7:0] rx_byte;
  logic       tmo;

  uart_byte_strobe u_strobe (
    .clk_i  (BPS_CLK),
    .rst_ni (RSTn),
    .done_i (RX_Done_Sig),
    .data_i (RX_Data),
    .acc_o  (acc),
    .byte_o (rx_byte)
  );

  assign tmo = (cnt_q == TMO_M1);

  // Slots past the current length may hold bytes of an older frame.
  always_comb begin
    fdata_d = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < len_q) begin
        fdata_d[k*8 +: 8] = buf_q[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge BPS_CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flen_q  <= '0;
      fdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // An accepted byte always wins over a same-cycle timeout.
      if (state_q != ST_IDLE) begin
        if (acc) begin
          cnt_q <= '0;
        end else if (tmo) begin
          cnt_q   <= '0;
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end

      if (acc) begin
        unique case (state_q)
          ST_IDLE: begin
            if (rx_byte == HEADER) begin
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_byte != 8'd0 && rx_byte <= MAXL) begin
              len_q   <= rx_byte[3:0];
              sum_q   <= rx_byte;
              idx_q   <= '0;
              state_q <= ST_PAYLOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            buf_q[{idx_q[2:0], 3'b000} +: 8] <= rx_byte;
            sum_q <= sum_q + rx_byte;
            idx_q <= idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) begin
              state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_byte == sum_q) begin
              fdata_q <= fdata_d;
              flen_q  <= len_q;
              done_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign FRAME_Done_Sig = done_q;
  assign FRAME_Err_Sig  = err_q;
  assign FRAME_Len      = flen_q;
  assign FRAME_Data     = fdata_q;
  assign Busy_Sig       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frames plus random frames
// checked against a byte-list model of the frame format.
module tb_uart_frame_parser;

  localparam int TMO = 64;

  logic        BPS_CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        RX_Done_Sig = 1'b0;
  logic [7:0]  RX_Data = 8'h00;
  logic        FRAME_Done_Sig;
  logic        FRAME_Err_Sig;
  logic [3:0]  FRAME_Len;
  logic [63:0] FRAME_Data;
  logic        Busy_Sig;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_err  = 0;

  logic [63:0] prev_data = '0;
  logic [3:0]  prev_len  = '0;
  logic [63:0] exp_data  = '0;
  logic [3:0]  exp_len   = '0;

  logic [7:0] seq[$];
  logic [7:0] pl[$];

  uart_frame_parser #(
    .HEADER  (8'hAA),
    .MAX_LEN (8),
    .TIMEOUT (TMO)
  ) dut (
    .BPS_CLK        (BPS_CLK),
    .RSTn           (RSTn),
    .RX_Done_Sig    (RX_Done_Sig),
    .RX_Data        (RX_Data),
    .FRAME_Done_Sig (FRAME_Done_Sig),
    .FRAME_Err_Sig  (FRAME_Err_Sig),
    .FRAME_Len      (FRAME_Len),
    .FRAME_Data     (FRAME_Data),
    .Busy_Sig       (Busy_Sig)
  );

  always #5 BPS_CLK = ~BPS_CLK;

  // Pulse bookkeeping and output-hold check, sampled on the falling edge.
  always @(negedge BPS_CLK) begin
    if (RSTn) begin
      checks++;
      if (FRAME_Done_Sig && FRAME_Err_Sig) begin
        errors++;
        $display("FAIL both_pulses done=%b err=%b expected not both",
                 FRAME_Done_Sig, FRAME_Err_Sig);
      end
      checks++;
      if (!FRAME_Done_Sig &&
          (FRAME_Data !== prev_data || FRAME_Len !== prev_len)) begin
        errors++;
        $display("FAIL hold data=%h len=%0d expected %h len %0d",
                 FRAME_Data, FRAME_Len, prev_data, prev_len);
      end
      if (FRAME_Done_Sig) n_done++;
      if (FRAME_Err_Sig) n_err++;
    end
    prev_data = FRAME_Data;
    prev_len  = FRAME_Len;
  end

  function automatic logic [63:0] pack_pl();
    logic [63:0] r = '0;
    for (int i = 0; i < pl.size(); i++) r[i*8 +: 8] = pl[i];
    return r;
  endfunction

  function automatic logic [7:0] csum_pl();
    int s = pl.size();
    for (int i = 0; i < pl.size(); i++) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  function automatic void build_frame(input logic [7:0] ck);
    seq.delete();
    seq.push_back(8'hAA);
    seq.push_back(8'(pl.size()));
    foreach (pl[i]) seq.push_back(pl[i]);
    seq.push_back(ck);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge BPS_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge BPS_CLK);
    RX_Done_Sig = 1'b1;
    RX_Data     = b;
    repeat (hold) @(negedge BPS_CLK);
    RX_Done_Sig = 1'b0;
  endtask

  // Returns on the falling edge after the last byte was accepted when hold=1.
  task automatic send_seq(input int hmax, input int gmax);
    for (int i = 0; i < seq.size(); i++) begin
      send_byte(seq[i], $urandom_range(1, hmax));
      if (i != seq.size() - 1) idle($urandom_range(0, gmax));
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle(3);
    checks += 5;
    if (FRAME_Done_Sig !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", FRAME_Done_Sig); end
    if (FRAME_Err_Sig !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", FRAME_Err_Sig); end
    if (FRAME_Len !== 4'd0) begin errors++; $display("FAIL rst_len got %0d exp 0", FRAME_Len); end
    if (FRAME_Data !== 64'd0) begin errors++; $display("FAIL rst_data got %h exp 0", FRAME_Data); end
    if (Busy_Sig !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", Busy_Sig); end
    RSTn = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    int d0 = n_done;
    pl = '{8'h11, 8'h22, 8'h33};
    build_frame(8'h69);
    exp_data = 64'h0000_0000_0033_2211;
    exp_len  = 4'd3;
    send_seq(1, 0);
    checks += 4;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL good_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Err_Sig !== 1'b0) begin errors++; $display("FAIL good_err got %b exp 0", FRAME_Err_Sig); end
    if (FRAME_Len !== exp_len) begin errors++; $display("FAIL good_len got %0d exp %0d", FRAME_Len, exp_len); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL good_data got %h exp %h", FRAME_Data, exp_data); end
    idle(1);
    checks += 3;
    if (FRAME_Done_Sig !== 1'b0) begin errors++; $display("FAIL good_pulse_width got %b exp 0", FRAME_Done_Sig); end
    if (Busy_Sig !== 1'b0) begin errors++; $display("FAIL good_busy got %b exp 0", Busy_Sig); end
    if (n_done - d0 !== 1) begin errors++; $display("FAIL good_count got %0d exp 1", n_done - d0); end
  endtask

  task automatic test_bad_csum();
    int d0 = n_done;
    int e0 = n_err;
    pl = '{8'h11, 8'h22, 8'h33};
    build_frame(8'h68);
    send_seq(1, 0);
    checks += 2;
    if (FRAME_Err_Sig !== 1'b1) begin errors++; $display("FAIL csum_err got %b exp 1", FRAME_Err_Sig); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL csum_keep got %h exp %h", FRAME_Data, exp_data); end
    idle(2);
    checks += 2;
    if (n_err - e0 !== 1) begin errors++; $display("FAIL csum_errcnt got %0d exp 1", n_err - e0); end
    if (n_done - d0 !== 0) begin errors++; $display("FAIL csum_donecnt got %0d exp 0", n_done - d0); end
  endtask

  task automatic test_wrap();
    pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    build_frame(8'h00);
    send_seq(1, 0);
    checks += 3;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Len !== 4'd8) begin errors++; $display("FAIL wrap_len got %0d exp 8", FRAME_Len); end
    if (FRAME_Data !== {64{1'b1}}) begin errors++; $display("FAIL wrap_data got %h exp all ones", FRAME_Data); end
    exp_data = {64{1'b1}};
    exp_len  = 4'd8;
    idle(2);
  endtask

  task automatic test_noise_len0();
    int d0 = n_done;
    int e0 = n_err;
    seq = '{8'h12, 8'hAA, 8'h00, 8'hAA, 8'h01, 8'h5A, 8'h5B};
    send_seq(1, 0);
    exp_data = 64'h5A;
    exp_len  = 4'd1;
    checks += 4;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL len0_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL len0_data got %h exp %h", FRAME_Data, exp_data); end
    if (FRAME_Len !== exp_len) begin errors++; $display("FAIL len0_len got %0d exp 1", FRAME_Len); end
    if (n_err - e0 !== 1) begin errors++; $display("FAIL len0_errcnt got %0d exp 1", n_err - e0); end
    idle(2);
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL len0_donecnt got %0d exp 1", n_done - d0); end
  endtask

  task automatic test_timeout();
    int e0 = n_err;
    seq = '{8'hAA, 8'h02, 8'h10};
    send_seq(1, 0);
    idle(TMO - 1);
    checks += 2;
    if (FRAME_Err_Sig !== 1'b0) begin errors++; $display("FAIL tmo_early got %b exp 0", FRAME_Err_Sig); end
    if (Busy_Sig !== 1'b1) begin errors++; $display("FAIL tmo_busy_before got %b exp 1", Busy_Sig); end
    idle(1);
    checks += 2;
    if (FRAME_Err_Sig !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", FRAME_Err_Sig); end
    if (Busy_Sig !== 1'b0) begin errors++; $display("FAIL tmo_busy_after got %b exp 0", Busy_Sig); end
    idle(8);
    checks++;
    if (n_err - e0 !== 1) begin errors++; $display("FAIL tmo_errcnt got %0d exp 1", n_err - e0); end
    pl = '{8'h33};
    build_frame(8'h34);
    send_seq(1, 0);
    exp_data = 64'h33;
    exp_len  = 4'd1;
    checks += 2;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL tmo_next_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL tmo_next_data got %h exp %h", FRAME_Data, exp_data); end
    idle(2);
  endtask

  task automatic test_timeout_priority();
    int e0 = n_err;
    seq = '{8'hAA, 8'h02, 8'h10};
    send_seq(1, 0);
    idle(TMO - 2);
    send_byte(8'h20, 1);
    send_byte(8'h32, 1);
    exp_data = 64'h2010;
    exp_len  = 4'd2;
    checks += 3;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL prio_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL prio_data got %h exp %h", FRAME_Data, exp_data); end
    if (n_err - e0 !== 0) begin errors++; $display("FAIL prio_errcnt got %0d exp 0", n_err - e0); end
    idle(2);
  endtask

  task automatic test_reset_midframe();
    int e0 = n_err;
    seq = '{8'hAA, 8'h02};
    send_seq(1, 0);
    RSTn = 1'b0;
    idle(2);
    checks += 4;
    if (FRAME_Err_Sig !== 1'b0) begin errors++; $display("FAIL mrst_err got %b exp 0", FRAME_Err_Sig); end
    if (FRAME_Data !== 64'd0) begin errors++; $display("FAIL mrst_data got %h exp 0", FRAME_Data); end
    if (FRAME_Len !== 4'd0) begin errors++; $display("FAIL mrst_len got %0d exp 0", FRAME_Len); end
    if (Busy_Sig !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b exp 0", Busy_Sig); end
    RSTn = 1'b1;
    idle(2);
    pl = '{8'h07};
    build_frame(8'h08);
    send_seq(1, 0);
    exp_data = 64'h07;
    exp_len  = 4'd1;
    checks += 3;
    if (FRAME_Done_Sig !== 1'b1) begin errors++; $display("FAIL mrst_next_done got %b exp 1", FRAME_Done_Sig); end
    if (FRAME_Data !== exp_data) begin errors++; $display("FAIL mrst_next_data got %h exp %h", FRAME_Data, exp_data); end
    if (n_err - e0 !== 0) begin errors++; $display("FAIL mrst_errcnt got %0d exp 0", n_err - e0); end
    idle(2);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int d0 = n_done;
      int e0 = n_err;
      int kind = $urandom_range(0, 9);
      int want_done = 0;
      int want_err = 0;
      logic [7:0] b;
      seq.delete();
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hAA);
        seq.push_back(b);
      end
      if (kind == 0) begin
        seq.push_back(8'hAA);
        seq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(9, 255)));
        want_err = 1;
      end else begin
        logic [7:0] ck;
        pl.delete();
        repeat ($urandom_range(1, 8)) pl.push_back(8'($urandom_range(0, 255)));
        ck = csum_pl();
        if (kind <= 2) begin
          ck = ck + 8'($urandom_range(1, 255));
          want_err = 1;
        end else begin
          want_done = 1;
          exp_data  = pack_pl();
          exp_len   = 4'(pl.size());
        end
        seq.push_back(8'hAA);
        seq.push_back(8'(pl.size()));
        foreach (pl[i]) seq.push_back(pl[i]);
        seq.push_back(ck);
      end
      send_seq(3, 4);
      idle(3);
      checks += 4;
      if (n_done - d0 !== want_done) begin errors++; $display("FAIL rnd%0d_done got %0d exp %0d", f, n_done - d0, want_done); end
      if (n_err - e0 !== want_err) begin errors++; $display("FAIL rnd%0d_err got %0d exp %0d", f, n_err - e0, want_err); end
      if (FRAME_Data !== exp_data) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", f, FRAME_Data, exp_data); end
      if (FRAME_Len !== exp_len) begin errors++; $display("FAIL rnd%0d_len got %0d exp %0d", f, FRAME_Len, exp_len); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_wrap();
    test_noise_len0();
    test_timeout();
    test_timeout_priority();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
